// File: rtl/reg_file_sb_rv32.sv
// ============================================================================
// reg_file_sb_rv32 : parametrised register file with write bypass, pending-write
//                    scoreboard and post-reset zeroing sweep.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_sb_rv32 #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            init_ready,
    input  logic            cu_rdwrite,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_in,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    localparam logic          BYP  = (BYPASS != 0);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [AW-1:0]          cnt;
    logic [XLEN-1:0]        rf [NREG];
    logic [NREG-1:0]        pending;
    logic [NREG-1:0]        pend_nxt;
    logic                   ready;
    logic                   wr_en;
    logic [1:0][AW-1:0]     raddr;
    logic [1:0][XLEN-1:0]   rdata;
    logic [1:0]             busy;

    assign ready      = (state == S_READY);
    assign init_ready = ready;
    assign wr_en      = ready && cu_rdwrite && (rd_addr != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == S_INIT) begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:  if (cnt == LAST) next_state = S_READY;
            S_READY: next_state = S_READY;
            default: next_state = S_INIT;
        endcase
    end

    // Storage has no reset so it can map onto distributed RAM; the sweep zeroes it.
    always_ff @(posedge clock) begin
        if (state == S_INIT) begin
            rf[cnt] <= '0;
        end else if (wr_en) begin
            rf[rd_addr] <= rd_in;
        end
    end

    // Set is applied after clear so a same-address issue keeps the newer producer pending.
    always_comb begin
        pend_nxt = pending;
        if (wr_en) begin
            pend_nxt[rd_addr] = 1'b0;
        end
        if (ready && issue_valid && (issue_addr != '0)) begin
            pend_nxt[issue_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    assign raddr[0] = rs1_addr;
    assign raddr[1] = rs2_addr;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic fwd;
        assign fwd      = BYP && cu_rdwrite && (rd_addr == raddr[p]);
        assign rdata[p] = (!ready || (raddr[p] == '0)) ? '0 :
                          fwd                          ? rd_in :
                                                         rf[raddr[p]];
        assign busy[p]  = ready && pending[raddr[p]] && !fwd;
    end

    assign rs1      = rdata[0];
    assign rs2      = rdata[1];
    assign rs1_busy = busy[0];
    assign rs2_busy = busy[1];

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb_rv32.sv
// ============================================================================
// tb_reg_file_sb_rv32 : self-checking bench for reg_file_sb_rv32 (bypass,
//                       no-bypass and 64-bit/16-entry variants).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_sb_rv32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        we = 1'b0, iv = 1'b0;
    logic [4:0]  rda = '0, a1 = '0, a2 = '0, ia = '0;
    logic [31:0] rdd = '0;
    logic [31:0] rs1, rs2, rs1_nb, rs2_nb;
    logic        b1, b2, b1_nb, b2_nb, rdy, rdy_nb;

    logic        we64 = 1'b0, iv64 = 1'b0;
    logic [3:0]  rda64 = '0, a1_64 = '0, a2_64 = '0, ia64 = '0;
    logic [63:0] rdd64 = '0;
    logic [63:0] rs1_64, rs2_64;
    logic        b1_64, b2_64, rdy64;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    reg_file_sb_rv32 dut (
        .clock(clock), .reset_n(reset_n), .init_ready(rdy),
        .cu_rdwrite(we), .rd_addr(rda), .rd_in(rdd),
        .rs1_addr(a1), .rs2_addr(a2), .rs1(rs1), .rs2(rs2),
        .issue_valid(iv), .issue_addr(ia), .rs1_busy(b1), .rs2_busy(b2)
    );

    reg_file_sb_rv32 #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .init_ready(rdy_nb),
        .cu_rdwrite(we), .rd_addr(rda), .rd_in(rdd),
        .rs1_addr(a1), .rs2_addr(a2), .rs1(rs1_nb), .rs2(rs2_nb),
        .issue_valid(iv), .issue_addr(ia), .rs1_busy(b1_nb), .rs2_busy(b2_nb)
    );

    reg_file_sb_rv32 #(.XLEN(64), .NREG(16)) dut64 (
        .clock(clock), .reset_n(reset_n), .init_ready(rdy64),
        .cu_rdwrite(we64), .rd_addr(rda64), .rd_in(rdd64),
        .rs1_addr(a1_64), .rs2_addr(a2_64), .rs1(rs1_64), .rs2(rs2_64),
        .issue_valid(iv64), .issue_addr(ia64), .rs1_busy(b1_64), .rs2_busy(b2_64)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rda;
        logic [31:0] rdd;
        logic [4:0]  a1, a2;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] e1, e2;
        logic        eb1, eb2;
        logic [31:0] e2nb;
        logic        eb2nb;
    } vec_t;

    vec_t vt [19];
    vec_t sbq [$];

    function automatic vec_t mk(input bit w, input int ra, input logic [31:0] rd,
                                input int x1, input int x2, input bit v, input int va,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input bit eb1, input bit eb2,
                                input logic [31:0] e2nb, input bit eb2nb);
        vec_t r;
        r.we = w;  r.rda = 5'(ra); r.rdd = rd;
        r.a1 = 5'(x1); r.a2 = 5'(x2);
        r.iv = v;  r.ia = 5'(va);
        r.e1 = e1; r.e2 = e2; r.eb1 = eb1; r.eb2 = eb2;
        r.e2nb = e2nb; r.eb2nb = eb2nb;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; rda = '0; rdd = '0; iv = 1'b0; ia = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;

        // Expected behaviour after a clean sweep; e2nb/eb2nb are the BYPASS=0 instance.
        vt[0]  = mk(0, 0, 32'h0,        0,  1, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        vt[1]  = mk(1, 5, 32'hDEADBEEF, 5,  0, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0);
        vt[2]  = mk(0, 0, 32'h0,        5,  5, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
        vt[3]  = mk(1, 0, 32'h12345678, 0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        vt[4]  = mk(0, 0, 32'h0,        0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        vt[5]  = mk(1, 7, 32'hA5A5A5A5, 5,  7, 0, 0,  32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'h0,        0);
        vt[6]  = mk(0, 0, 32'h0,        5,  7, 0, 0,  32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0);
        vt[7]  = mk(0, 0, 32'h0,        9,  9, 1, 9,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        vt[8]  = mk(0, 0, 32'h0,        9,  9, 0, 0,  32'h0,        32'h0,        1, 1, 32'h0,        1);
        vt[9]  = mk(1, 9, 32'h11111111, 9,  9, 0, 0,  32'h11111111, 32'h11111111, 0, 0, 32'h0,        1);
        vt[10] = mk(0, 0, 32'h0,        9,  9, 0, 0,  32'h11111111, 32'h11111111, 0, 0, 32'h11111111, 0);
        vt[11] = mk(0, 0, 32'h0,        9,  9, 1, 9,  32'h11111111, 32'h11111111, 0, 0, 32'h11111111, 0);
        vt[12] = mk(0, 0, 32'h0,        9,  9, 0, 0,  32'h11111111, 32'h11111111, 1, 1, 32'h11111111, 1);
        vt[13] = mk(1, 9, 32'h22222222, 9,  9, 1, 9,  32'h22222222, 32'h22222222, 0, 0, 32'h11111111, 1);
        vt[14] = mk(0, 0, 32'h0,        9,  9, 0, 0,  32'h22222222, 32'h22222222, 1, 1, 32'h22222222, 1);
        vt[15] = mk(1, 9, 32'h33333333, 9, 10, 1, 10, 32'h33333333, 32'h0,        0, 0, 32'h0,        0);
        vt[16] = mk(0, 0, 32'h0,        9, 10, 0, 0,  32'h33333333, 32'h0,        0, 1, 32'h0,        1);
        vt[17] = mk(0, 0, 32'h0,        0,  0, 1, 0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        vt[18] = mk(0, 0, 32'h0,        0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0,        0);

        // Reset state and sweep timing
        a1 = 5'd5;
        #2;
        chk("reset_init_ready", {63'b0, rdy}, 64'd0);
        chk("reset_rs1", {32'b0, rs1}, 64'd0);
        chk("reset_busy", {63'b0, b1}, 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("sweep32_edge%0d", k), {63'b0, rdy}, {63'b0, (k == 32)});
            if (k == 16 || k == 15)
                chk($sformatf("sweep16_edge%0d", k), {63'b0, rdy64}, {63'b0, (k >= 16)});
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clock);
            a1 = 5'(a);
            a1_64 = 4'(a);
            #2;
            chk($sformatf("zero_rd_x%0d", a), {32'b0, rs1}, 64'd0);
            if (a < 16) chk($sformatf("zero_rd64_x%0d", a), rs1_64, 64'd0);
        end

        // 64-bit variant: bypass on the write cycle, then stored value
        @(negedge clock);
        we64 = 1'b1; rda64 = 4'd15; rdd64 = 64'hFFFF_0000_FFFF_0000; a1_64 = 4'd15; a2_64 = 4'd0;
        #2;
        chk("w64_bypass", rs1_64, 64'hFFFF_0000_FFFF_0000);
        @(negedge clock);
        we64 = 1'b0; rdd64 = '0;
        #2;
        chk("w64_readback", rs1_64, 64'hFFFF_0000_FFFF_0000);
        chk("w64_x0", rs2_64, 64'd0);

        // Table-driven vectors through the scoreboard queue
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            we = vt[i].we; rda = vt[i].rda; rdd = vt[i].rdd;
            a1 = vt[i].a1; a2 = vt[i].a2; iv = vt[i].iv; ia = vt[i].ia;
            sbq.push_back(vt[i]);
            #2;
            e = sbq.pop_front();
            chk($sformatf("v%0d_rs1", i), {32'b0, rs1}, {32'b0, e.e1});
            chk($sformatf("v%0d_rs2", i), {32'b0, rs2}, {32'b0, e.e2});
            chk($sformatf("v%0d_busy1", i), {63'b0, b1}, {63'b0, e.eb1});
            chk($sformatf("v%0d_busy2", i), {63'b0, b2}, {63'b0, e.eb2});
            chk($sformatf("v%0d_nb_rs2", i), {32'b0, rs2_nb}, {32'b0, e.e2nb});
            chk($sformatf("v%0d_nb_busy2", i), {63'b0, b2_nb}, {63'b0, e.eb2nb});
        end
        idle();

        // Asynchronous drop of init_ready, then a reset pulse mid-sweep
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("async_drop", {63'b0, rdy}, 64'd0);
        chk("async_drop_nb", {63'b0, rdy_nb}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        we = 1'b1; rda = 5'd3; rdd = 32'hFFFFFFFF; iv = 1'b1; ia = 5'd3; a1 = 5'd5; a2 = 5'd3;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("mid_edge%0d_ready", k), {63'b0, rdy}, 64'd0);
            chk($sformatf("mid_edge%0d_rs1", k), {32'b0, rs1}, 64'd0);
            chk($sformatf("mid_edge%0d_busy2", k), {63'b0, b2}, 64'd0);
        end
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("resweep_edge%0d", k), {63'b0, rdy}, {63'b0, (k == 32)});
        end
        idle();
        a1 = 5'd3; a2 = 5'd3;
        #1;
        chk("init_wr_x3_rs1", {32'b0, rs1}, 64'd0);
        chk("init_wr_x3_rs2_nb", {32'b0, rs2_nb}, 64'd0);
        chk("init_issue_x3_busy1", {63'b0, b1}, 64'd0);
        chk("init_issue_x3_busy2_nb", {63'b0, b2_nb}, 64'd0);
        a1 = 5'd5;
        #1;
        chk("resweep_x5_zero", {32'b0, rs1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_sb_rv32.md
Name: reg_file_sb_rv32

Overview:
- Parametrised successor of the RV32I integer register file. Adds a configurable width and depth, optional write-to-read bypass, and a per-register pending-write scoreboard for the pipelined core.
- Adds a post-reset zeroing sweep FSM, so the storage array needs no reset and can map to distributed RAM.
- Sits between decode (read ports, issue) and writeback (write port) of the core.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREG, 32, number of registers. Must be a power of 2 and at least 2.
- AW, $clog2(NREG), address width. Derived; never overridden.
- BYPASS, 1, 1 enables combinational write-to-read forwarding; 0 disables it.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- init_ready  out  1  high once the zeroing sweep is complete.
- cu_rdwrite  in  1  write enable from writeback.
- rd_addr  in  AW  write address.
- rd_in  in  XLEN  write data.
- rs1_addr  in  AW  read address, port 1.
- rs2_addr  in  AW  read address, port 2.
- rs1  out  XLEN  read data, port 1 (asynchronous read).
- rs2  out  XLEN  read data, port 2 (asynchronous read).
- issue_valid  in  1  decode issued an instruction that will write issue_addr.
- issue_addr  in  AW  destination register of the issued instruction.
- rs1_busy  out  1  rs1_addr has an outstanding write.
- rs2_busy  out  1  rs2_addr has an outstanding write.

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-low on reset_n.
- On reset assertion: state=INIT, sweep counter cnt=0, init_ready=0, all pending bits=0. The storage array is not reset.
- INIT state:
  - Each rising edge writes 0 to rf[cnt] and increments cnt.
  - The edge that writes rf[NREG-1] moves the state to READY.
  - init_ready rises on that same edge, i.e. exactly NREG clocks after reset_n deasserts.
- During INIT:
  - cu_rdwrite and issue_valid are ignored.
  - rs1 and rs2 read 0; rs1_busy and rs2_busy read 0.
- READY state, writes: on a rising edge with cu_rdwrite=1 and rd_addr!=0, rf[rd_addr] <= rd_in.
- Register 0: writes to address 0 are dropped. rsN reads 0 whenever rsN_addr==0, regardless of bypass.
- Read path:
  - rsN = rf[rsN_addr], combinational.
  - When BYPASS=1 and cu_rdwrite=1 and rd_addr==rsN_addr!=0, rsN = rd_in in the same cycle.
  - When BYPASS=0, rsN shows the new value only from the cycle after the write edge.
- Scoreboard (pending[NREG], flops, asynchronous clear on reset):
  - Set: issue_valid=1 and issue_addr!=0 sets pending[issue_addr] at the edge.
  - Clear: a write (cu_rdwrite=1, rd_addr!=0) clears pending[rd_addr] at the edge.
  - Same address in the same cycle: set wins, because the newer producer remains outstanding.
  - Different addresses in the same cycle: both actions apply.
  - pending[0] is constant 0.
- Busy outputs:
  - rsN_busy = pending[rsN_addr].
  - If BYPASS=1, rsN_busy is forced to 0 in a cycle where the write port targets rsN_addr, because the data is forwarded.
- Reset mid-sweep or mid-operation: returns to INIT with cnt=0, init_ready drops asynchronously, and the sweep restarts from register 0.
- cnt is AW bits wide. Wrap from NREG-1 to 0 is a don't-care because the state leaves INIT on that edge.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Sweep timing: assert reset_n=0 for 3 clocks, then release, with NREG=32 → init_ready=0 for 31 edges and 1 after the 32nd edge. Then reading every address on rs1 returns 0x00000000.
- Write/read: write x5=0xDEADBEEF → rs1_addr=5 reads 0xDEADBEEF in the following cycle. Writing x0=0x12345678 → rs2_addr=0 reads 0.
- Bypass: with BYPASS=1, cu_rdwrite=1, rd_addr=7, rd_in=0xA5A5A5A5 and rs2_addr=7 in the same cycle → rs2=0xA5A5A5A5 and rs2_busy=0 before the edge. With BYPASS=0 the same stimulus gives rs2 = the old value.
- Scoreboard set and clear:
  - issue_valid with issue_addr=9 → rs1_busy=1 for rs1_addr=9 on the next cycle.
  - A later write to x9 → busy=0 after that edge.
  - Simultaneous issue and write to x9 → busy stays 1.
- Mid-sweep reset: pulse reset_n low at sweep cycle 10 → init_ready stays 0 and needs a full 32 further clocks. Writes and issues during INIT have no effect: x3 reads 0 and busy reads 0 afterwards.
- Parameter variant: XLEN=64, NREG=16, then write x15=0xFFFF_0000_FFFF_0000 → reads back exactly; init_ready asserts after 16 clocks.
